// File: rtl/counter_ctrl_if.sv
// Button inputs and datapath command outputs of counter_ctrl, bundled for the port list.
// inc/dec/clr/tick are single-cycle strobes with no ready: the datapath must accept any cycle they are high.
interface counter_ctrl_if;
  logic [3:0] buttons;
  logic       inc;
  logic       dec;
  logic       clr;
  logic       tick;
  logic [1:0] mode;

  modport master (output buttons, input inc, dec, clr, tick, mode);
  modport slave  (input buttons, output inc, dec, clr, tick, mode);
endinterface

// File: rtl/counter_ctrl.sv
// Button front end, run-mode FSM and auto-step timer driving a 4-bit up/down counter datapath.
// Priority per cycle: clear edge, up edge, down edge, auto-step (auto-step may wait one-deep).
module counter_ctrl #(
  parameter int CYCLES_PER_SECOND = 125_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  counter_ctrl_if.slave  bus
);

  localparam int            CW   = $clog2(CYCLES_PER_SECOND);
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_SECOND - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_UP   = 2'b01,
    RUN_DOWN = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    prev_q, prev_d;
  logic [3:0]    arm_q, arm_d;
  logic [1:0]    fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;
  logic          clr_q, clr_d;
  logic          tick_q, tick_d;

  logic [3:0]    edges;
  logic          clr_edge, up_edge, dn_edge, mode_edge;
  logic          running, wrap, manual;

  always_comb begin
    sync1_d   = bus.buttons;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    fill_d    = (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
    // A bit only arms after the synchronizer holds real post-reset data that is low,
    // so a button held through reset release never looks like a fresh press.
    arm_d     = arm_q | ((fill_q == 2'd2) ? ~sync2_q : 4'b0000);

    edges     = sync2_q & ~prev_q & arm_q;
    up_edge   = edges[0];
    dn_edge   = edges[1];
    mode_edge = edges[2];
    clr_edge  = edges[3];
    manual    = clr_edge | up_edge | dn_edge;

    state_d = state_q;
    if (mode_edge) begin
      case (state_q)
        IDLE:     state_d = RUN_UP;
        RUN_UP:   state_d = RUN_DOWN;
        RUN_DOWN: state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end

    running = (state_q != IDLE);
    wrap    = running && (cnt_q == LAST) && !mode_edge && !clr_edge;

    if (!running || mode_edge || clr_edge) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    tick_d = wrap;
    inc_d  = 1'b0;
    dec_d  = 1'b0;
    clr_d  = 1'b0;
    pend_d = pend_q;

    if (clr_edge) begin
      clr_d = 1'b1;
    end else if (up_edge) begin
      inc_d = 1'b1;
    end else if (dn_edge) begin
      dec_d = 1'b1;
    end else if (!mode_edge && (pend_q || wrap)) begin
      // If a fresh auto-step meets a pending one, only one issues; the other is discarded.
      inc_d = (state_q == RUN_UP);
      dec_d = (state_q == RUN_DOWN);
    end

    if (mode_edge || clr_edge) begin
      pend_d = 1'b0;
    end else if (manual) begin
      pend_d = pend_q | wrap;
    end else if (pend_q || wrap) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      clr_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      clr_q   <= clr_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.inc  = inc_q;
  assign bus.dec  = dec_q;
  assign bus.clr  = clr_q;
  assign bus.tick = tick_q;
  assign bus.mode = state_q;

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_SECOND, default 125_000_000, the auto-step period in clk cycles (legal range 2 to 2^27-1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-004 The block SHALL have port buttons, input, 4 bits, asynchronous: [0] step up, [1] step down, [2] mode advance, [3] clear.
REQ-005 The block SHALL have port inc, output, 1 bit: a one-cycle increment command to the 4-bit counter datapath.
REQ-006 The block SHALL have port dec, output, 1 bit: a one-cycle decrement command to the counter datapath.
REQ-007 The block SHALL have port clr, output, 1 bit: a one-cycle clear command to the counter datapath.
REQ-008 The block SHALL have port mode, output, 2 bits: the current run state (00 IDLE, 01 RUN_UP, 10 RUN_DOWN; 11 is never driven).
REQ-009 The block SHALL have port tick, output, 1 bit: a one-cycle pulse when the period counter expires.

Function
REQ-010 Each button bit SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; no debounce is required, because debounce is handled upstream.
REQ-011 A button press SHALL produce at most one command pulse per rising edge, regardless of hold duration.
REQ-012 Latency SHALL be: command output high in the cycle after the 3rd rising clk edge at which the button is sampled high, counting the first sampling edge as edge 1.
REQ-013 inc, dec and clr SHALL be registered outputs and mutually exclusive; at most one of them SHALL be high in any cycle.
REQ-014 Command priority within one cycle SHALL be, highest first: clear edge, up edge, down edge, auto-step.
REQ-015 Requests that lose arbitration in a cycle SHALL be dropped, except the auto-step, which is handled by REQ-020.
REQ-016 The state machine SHALL have states IDLE, RUN_UP and RUN_DOWN.
REQ-017 Each mode-advance edge SHALL move the state IDLE->RUN_UP->RUN_DOWN->IDLE, with the new state visible on mode in the same cycle a command from the same edge would appear.
REQ-018 Period counter: it SHALL count 0..CYCLES_PER_SECOND-1 only in RUN_UP or RUN_DOWN, and SHALL hold at 0 in IDLE.
REQ-019 On wrap from CYCLES_PER_SECOND-1 to 0, tick SHALL pulse for 1 cycle, and the block SHALL raise an auto-step request of inc (RUN_UP) or dec (RUN_DOWN).
REQ-020 An auto-step blocked by a higher-priority command SHALL set a 1-deep pending flag and issue in the first following cycle with no manual command.
REQ-021 A second auto-step arriving while the pending flag is set SHALL be discarded.
REQ-022 The period counter and pending flag SHALL clear on any state transition and on a clear edge; mode SHALL be unchanged by clear.
REQ-023 The block SHALL NOT observe the count value; 4-bit wrap-around (15+1=0, 0-1=15) belongs to the datapath.
REQ-024 Manual up/down edges SHALL be honoured in every state, including IDLE.

Reset
REQ-025 With rst_n sampled low at a rising edge, the block SHALL in the next cycle drive inc=0, dec=0, clr=0, tick=0 and mode=00, and SHALL zero the period counter, pending flag, synchronizers and edge-detector history.
REQ-026 Reset SHALL override any in-flight command, including one asserted mid-operation in RUN_UP.
REQ-027 A button held high through reset release SHALL NOT produce a command.

Verification (CYCLES_PER_SECOND=8)
REQ-028 Bench scenario: pulse buttons[0] high for 20 cycles -> exactly one inc, high 3 edges after the first sample; no further pulses.
REQ-029 Bench scenario: press buttons[2] once -> mode=01, then tick and inc every 8 cycles; 4 presses total -> mode sequence 01,10,00,01.
REQ-030 Bench scenario: in RUN_UP, press buttons[1] so its edge lands on the tick cycle -> dec in that cycle, inc in the next cycle; with two consecutive manual commands, inc is delayed two cycles.
REQ-031 Bench scenario: assert buttons[0] and buttons[3] edges in the same cycle -> clr only, and the period counter restarts from 0.
REQ-032 Bench scenario: in RUN_DOWN at period count 5, drive rst_n low for 1 cycle -> mode=00 and all outputs 0; no tick for 8+ cycles after release.
REQ-033 Bench scenario: hold buttons[2] high across reset release -> mode stays 00.
